// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
//   Shared definitions for the FFT output serializer slice:
//     - default data width and frame length
//     - serializer state enum {IDLE, CAPTURE, DRAIN}
//     - bitrev(): reverses the low 'w' bits of an address
// ---------------------------------------------------------------------------
package fft_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int N_PTS_DEF  = 64;
  localparam int ADDR_W_DEF = 6;

  // Widest address bitrev() can handle; callers cast down to their ADDR_W.
  localparam int MAX_ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  // Reverse bits [w-1:0] of a; bits at and above w come back as zero.
  function automatic logic [MAX_ADDR_W-1:0] bitrev(input logic [MAX_ADDR_W-1:0] a,
                                                   input int unsigned         w);
    logic [MAX_ADDR_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_ADDR_W; i++) begin
      if (i < int'(w)) r[i] = a[int'(w) - 1 - i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_ram.sv
// ---------------------------------------------------------------------------
// fft_frame_ram
//   N_PTS x (2*DATA_W) register array holding one complex FFT frame.
//   Two write ports (one FFT sample pair per cycle) and one registered read
//   port whose output register is the serializer's m_real/m_imag.
//
//   Ports:
//     clk, nrst            clock, synchronous active-low reset (read reg only)
//     wr_en                write both ports this cycle
//     wr_addr0/wr_data0    even-sample write port
//     wr_addr1/wr_data1    odd-sample write port (never equal to wr_addr0)
//     rd_en, rd_addr       load rd_data from rd_addr at the next edge
//     rd_data              registered read data {real, imag}
// ---------------------------------------------------------------------------
module fft_frame_ram
  import fft_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int N_PTS  = N_PTS_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr0,
  input  logic [2*DATA_W-1:0] wr_data0,
  input  logic [ADDR_W-1:0]   wr_addr1,
  input  logic [2*DATA_W-1:0] wr_data1,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [2*DATA_W-1:0] rd_data
);

  logic [2*DATA_W-1:0] mem [N_PTS];

  // NOTE: the array itself has no reset; its contents are always overwritten
  // by a full capture before being read, and leaving it unreset keeps it a
  // plain register file with no reset fan-out.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr0] <= wr_data0;
      mem[wr_addr1] <= wr_data1;
    end
  end

  // The read register is visible on the outputs, so it is reset to zero.
  always_ff @(posedge clk) begin
    if (!nrst)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fft_out_serializer.sv
// ---------------------------------------------------------------------------
// fft_out_serializer
//   Captures one N_PTS-point FFT burst (two complex samples per cycle) into a
//   frame buffer, then streams it out one sample per cycle on a valid/ready
//   interface with a last marker and bin index.
//
//   Build option: define BITREV_EN when the FFT emits bit-reversed order;
//   samples are then stored at bit-reversed addresses so the drain is in
//   natural bin order. Undefined: output order equals arrival order.
//
//   Ports:
//     clk, nrst                 clock, synchronous active-low reset
//     output_start              FFT pulse marking the first sample pair
//     outReal0/outImag0         even sample of the current pair
//     outReal1/outImag1         odd sample of the current pair
//     m_valid/m_ready           output handshake
//     m_real/m_imag             output sample
//     m_last                    final sample of the frame (index N_PTS-1)
//     m_index                   bin index of the output sample
//     busy                      high in CAPTURE or DRAIN
//     overrun                   sticky: output_start seen outside IDLE
// ---------------------------------------------------------------------------
module fft_out_serializer
  import fft_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int N_PTS  = N_PTS_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              output_start,
  input  logic [DATA_W-1:0] outReal0,
  input  logic [DATA_W-1:0] outImag0,
  input  logic [DATA_W-1:0] outReal1,
  input  logic [DATA_W-1:0] outImag1,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_real,
  output logic [DATA_W-1:0] m_imag,
  output logic              m_last,
  output logic [ADDR_W-1:0] m_index,
  output logic              busy,
  output logic              overrun
);

  localparam logic [ADDR_W-2:0] PAIR_LAST = '1;  // pair N_PTS/2-1
  localparam logic [ADDR_W-1:0] PTR_LAST  = '1;  // sample N_PTS-1

  state_t              state_q, state_d;
  logic [ADDR_W-2:0]   pair_q, pair_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                overrun_q, overrun_d;

  logic                wr_en, rd_en;
  logic [ADDR_W-1:0]   rd_addr;
  logic [ADDR_W-1:0]   sample0, sample1, wr_addr0, wr_addr1;
  logic [2*DATA_W-1:0] rd_data;

  assign sample0 = {pair_q, 1'b0};
  assign sample1 = {pair_q, 1'b1};

`ifdef BITREV_EN
  assign wr_addr0 = ADDR_W'(bitrev(MAX_ADDR_W'(sample0), ADDR_W));
  assign wr_addr1 = ADDR_W'(bitrev(MAX_ADDR_W'(sample1), ADDR_W));
`else
  assign wr_addr0 = sample0;
  assign wr_addr1 = sample1;
`endif

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    pair_d    = pair_q;
    ptr_d     = ptr_q;
    overrun_d = overrun_q;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = ptr_q;

    unique case (state_q)
      IDLE: begin
        // pair_q is 0 here, so the starting pair lands at samples 0 and 1.
        if (output_start) begin
          wr_en   = 1'b1;
          pair_d  = pair_q + 1'b1;
          state_d = CAPTURE;
        end
      end

      CAPTURE: begin
        // The FFT cannot be stalled: a pair is written every cycle and a
        // stray start pulse only flags the overrun.
        wr_en     = 1'b1;
        pair_d    = pair_q + 1'b1;
        if (output_start) overrun_d = 1'b1;
        if (pair_q == PAIR_LAST) begin
          // Prefetch sample 0 so it is on the outputs the first DRAIN cycle.
          state_d = DRAIN;
          pair_d  = '0;
          ptr_d   = '0;
          rd_en   = 1'b1;
          rd_addr = '0;
        end
      end

      DRAIN: begin
        if (output_start) overrun_d = 1'b1;
        if (m_ready) begin
          if (ptr_q == PTR_LAST) begin
            state_d = IDLE;
            ptr_d   = '0;
          end else begin
            // Read the next sample on the accepting edge: no bubbles.
            ptr_d   = ptr_q + 1'b1;
            rd_en   = 1'b1;
            rd_addr = ptr_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q   <= IDLE;
      pair_q    <= '0;
      ptr_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pair_q    <= pair_d;
      ptr_q     <= ptr_d;
      overrun_q <= overrun_d;
    end
  end

  fft_frame_ram #(
    .DATA_W (DATA_W),
    .N_PTS  (N_PTS),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk      (clk),
    .nrst     (nrst),
    .wr_en    (wr_en),
    .wr_addr0 (wr_addr0),
    .wr_data0 ({outReal0, outImag0}),
    .wr_addr1 (wr_addr1),
    .wr_data1 ({outReal1, outImag1}),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

  assign m_valid = (state_q == DRAIN);
  assign m_last  = m_valid && (ptr_q == PTR_LAST);
  assign m_index = ptr_q;
  assign m_real  = rd_data[2*DATA_W-1:DATA_W];
  assign m_imag  = rd_data[DATA_W-1:0];
  assign busy    = (state_q != IDLE);
  assign overrun = overrun_q;

endmodule

// File: tb/tb_fft_out_serializer.sv
// ---------------------------------------------------------------------------
// tb_fft_out_serializer
//   Self-checking bench for fft_out_serializer (N_PTS=64, DATA_W=16).
//   A table of frame scenarios (ready pattern, stray start pulses, data kind,
//   expected final overrun) is run in a loop; each frame is checked every
//   cycle against a reference built from the frame contents and output-order
//   rule. Hand-written sequences cover reset, back-to-back frames and reset
//   in the middle of a drain. Compile with +define+BITREV_EN for that build.
// ---------------------------------------------------------------------------
module tb_fft_out_serializer;

  localparam int DATA_W = 16;
  localparam int N_PTS  = 64;
  localparam int ADDR_W = 6;
  localparam int HALF   = N_PTS / 2;

  logic              clk = 1'b0;
  logic              nrst;
  logic              output_start;
  logic [DATA_W-1:0] outReal0, outImag0, outReal1, outImag1;
  logic              m_valid, m_ready, m_last, busy, overrun;
  logic [DATA_W-1:0] m_real, m_imag;
  logic [ADDR_W-1:0] m_index;

  always #5 clk = ~clk;

  fft_out_serializer #(
    .DATA_W (DATA_W),
    .N_PTS  (N_PTS),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk          (clk),
    .nrst         (nrst),
    .output_start (output_start),
    .outReal0     (outReal0),
    .outImag0     (outImag0),
    .outReal1     (outReal1),
    .outImag1     (outImag1),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_real       (m_real),
    .m_imag       (m_imag),
    .m_last       (m_last),
    .m_index      (m_index),
    .busy         (busy),
    .overrun      (overrun)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [DATA_W-1:0] fr_re [N_PTS];   // frame in FFT arrival order
  logic [DATA_W-1:0] fr_im [N_PTS];
  bit                ovr_model;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic int bitrev_ref(input int v);
    int r = 0;
    for (int i = 0; i < ADDR_W; i++) r = r * 2 + ((v >> i) & 1);
    return r;
  endfunction

  // Arrival position of the sample that must appear at output bin j.
  function automatic int src_of_bin(input int j);
`ifdef BITREV_EN
    return bitrev_ref(j);
`else
    return j;
`endif
  endfunction

  task automatic fill_frame(input bit rnd);
    for (int s = 0; s < N_PTS; s++) begin
      fr_re[s] = rnd ? DATA_W'($urandom) : DATA_W'(s);
      fr_im[s] = rnd ? DATA_W'($urandom) : DATA_W'(-s);
    end
  endtask

  task automatic apply_reset();
    nrst         = 1'b0;
    output_start = 1'b0;
    m_ready      = 1'b1;
    @(negedge clk);
    nrst      = 1'b1;
    ovr_model = 1'b0;
  endtask

  // Runs one frame from the current negedge. ready_mode: 0 = always 1,
  // 1 = pattern 1,0,0,1, 2 = random. ovr1/ovr2: extra start pulse cycles
  // (-1 for none). stop_after >= 0 returns while bin stop_after is offered.
  task automatic run_frame(input int ready_mode, input int ovr1, input int ovr2,
                           input int stop_after);
    int  cnt  = 0;
    bit  done = 1'b0;
    bit  exp_valid, exp_busy, set_ovr;
    logic [41:0] act, exp, mask;
    for (int t = 0; t < 600; t++) begin
      exp_valid = (t >= HALF) && !done;
      exp_busy  = (t > 0) && !done;
      act  = {busy, overrun, m_valid, m_last, m_index, m_real, m_imag};
      mask = exp_valid ? '1 : {4'hF, 38'd0};
      exp  = {exp_busy, ovr_model, exp_valid, exp_valid && (cnt == N_PTS - 1),
              exp_valid ? ADDR_W'(cnt) : ADDR_W'(0),
              exp_valid ? fr_re[src_of_bin(cnt)] : DATA_W'(0),
              exp_valid ? fr_im[src_of_bin(cnt)] : DATA_W'(0)};
      check("cycle", 64'(act & mask), 64'(exp));
      if (done) return;
      if (stop_after >= 0 && exp_valid && cnt == stop_after) return;

      output_start = (t == 0) || (t == ovr1) || (t == ovr2);
      if (t < HALF) begin
        outReal0 = fr_re[2*t];   outImag0 = fr_im[2*t];
        outReal1 = fr_re[2*t+1]; outImag1 = fr_im[2*t+1];
      end else begin
        outReal0 = DATA_W'($urandom); outImag0 = DATA_W'($urandom);
        outReal1 = DATA_W'($urandom); outImag1 = DATA_W'($urandom);
      end
      case (ready_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (t % 4 == 0) || (t % 4 == 3);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      set_ovr = output_start && (t > 0);
      if (exp_valid && m_ready) begin
        cnt++;
        if (cnt == N_PTS) done = 1'b1;
      end
      @(negedge clk);
      output_start = 1'b0;
      if (set_ovr) ovr_model = 1'b1;
    end
    check("frame_done", 64'(cnt), 64'(N_PTS));
  endtask

  typedef struct {
    string name;
    int    ready_mode;
    int    ovr1;
    int    ovr2;
    bit    rnd;
    bit    exp_ovr;
  } vec_t;

  vec_t tbl [6];

  initial begin
    tbl[0] = '{"ramp_ready1",    0, -1, -1, 1'b0, 1'b0};
    tbl[1] = '{"ramp_backpress", 1, -1, -1, 1'b0, 1'b0};
    tbl[2] = '{"ramp_overrun",   0, 10, 40, 1'b0, 1'b1};
    tbl[3] = '{"start_at_last",  0, -1, 95, 1'b0, 1'b1};  // 95 = final handshake
    tbl[4] = '{"rand_ready",     2, -1, -1, 1'b1, 1'b0};
    tbl[5] = '{"rand_overrun",   2, 20, -1, 1'b1, 1'b1};

    nrst = 1'b0; output_start = 1'b0; m_ready = 1'b0; ovr_model = 1'b0;
    outReal0 = '0; outImag0 = '0; outReal1 = '0; outImag1 = '0;
    repeat (3) @(negedge clk);
    check("reset_state",
          64'({m_valid, m_last, m_index, m_real, m_imag, busy, overrun}), 64'(0));
    nrst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      apply_reset();
      fill_frame(tbl[i].rnd);
      run_frame(tbl[i].ready_mode, tbl[i].ovr1, tbl[i].ovr2, -1);
      check({tbl[i].name, "_overrun"}, 64'(overrun), 64'(tbl[i].exp_ovr));
      repeat (3) @(negedge clk);
      check({tbl[i].name, "_idle"}, 64'({busy, m_valid}), 64'(0));
    end

    // Back-to-back: second start one cycle after the last handshake.
    apply_reset();
    fill_frame(1'b0);
    run_frame(0, -1, -1, -1);
    fill_frame(1'b1);
    run_frame(2, -1, -1, -1);
    check("b2b_overrun", 64'(overrun), 64'(0));

    // Reset in the middle of a drain, after 20 handshakes.
    apply_reset();
    fill_frame(1'b1);
    run_frame(1, 5, -1, 20);
    nrst = 1'b0; output_start = 1'b0; m_ready = 1'b1;
    @(negedge clk);
    check("mid_reset", 64'({m_valid, busy, overrun, m_last, m_index}), 64'(0));
    nrst = 1'b1; ovr_model = 1'b0;
    @(negedge clk);
    fill_frame(1'b1);
    run_frame(2, -1, -1, -1);
    check("post_reset_overrun", 64'(overrun), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
